can_frame_sequencer: RTL and testbench

- Bit-level field sequencer for the CAN receive path.
- Consumes destuffed, sampled bits. Tracks frame position from SOF to EOF and drives the enable/clear of the downstream capture block.
- Latches IDE/RTR/DLC and flags frame completion and form errors.
- Sits between the bit-timing/destuff stage and the capture/decode logic.

---
 rtl/can_frame_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_can_frame_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_sequencer.sv
// can_frame_sequencer: bit-level field tracker for the CAN receive path.
// Consumes destuffed sampled bits, walks the frame from SOF to EOF, drives
// the capture block's clear/enable, latches IDE/RTR/DLC and flags frame
// completion and form errors.
// Optional feature macro: CAN_CRC_CHECK_EN adds a CRC-15 checker and the
// crc_err output.
// Handshake: a bit is consumed only on a cycle with bit_valid=1 (a one-cycle
// strobe, no backpressure); all pulse outputs are one cycle wide.
module can_frame_sequencer #(
    parameter int IDLE_BITS = 11,
    parameter int MAX_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_valid,
    input  logic       rx_bit,
    output logic       cap_clr,
    output logic       cap_en,
    output logic [3:0] field,
    output logic [6:0] bit_cnt,
    output logic       ide,
    output logic       rtr,
    output logic [3:0] dlc,
    output logic       frame_done,
`ifdef CAN_CRC_CHECK_EN
    output logic       crc_err,
`endif
    output logic       form_err
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INTEG   = 4'd1,
        ST_ID_A    = 4'd2,
        ST_SRR_RTR = 4'd3,
        ST_IDE     = 4'd4,
        ST_ID_B    = 4'd5,
        ST_RTR_B   = 4'd6,
        ST_R1      = 4'd7,
        ST_R0      = 4'd8,
        ST_DLC     = 4'd9,
        ST_DATA    = 4'd10,
        ST_CRC     = 4'd11,
        ST_CRC_DEL = 4'd12,
        ST_ACK     = 4'd13,
        ST_ACK_DEL = 4'd14,
        ST_EOF     = 4'd15
    } state_t;

    localparam logic [6:0] INTEG_LAST  = 7'(IDLE_BITS - 1);
    localparam logic [3:0] MAX_BYTES_L = 4'(MAX_BYTES);

    state_t     state_q, state_d;
    logic [6:0] bit_cnt_q, bit_cnt_d;
    logic       ide_q, ide_d;
    logic       rtr_q, rtr_d;
    logic [3:0] dlc_q, dlc_d;
    logic       cap_clr_q, cap_clr_d;
    logic       frame_done_q, frame_done_d;
    logic       form_err_q, form_err_d;

    // Data field length in bits: clamped byte count times 8, none for remote frames.
    function automatic logic [6:0] data_len(input logic [3:0] d, input logic r);
        logic [3:0] n;
        n = (d > MAX_BYTES_L) ? MAX_BYTES_L : d;
        return r ? 7'd0 : {n, 3'b000};
    endfunction

`ifdef CAN_CRC_CHECK_EN
    logic [14:0] crc_q, crc_d;
    logic        crc_bad_q, crc_bad_d;
    logic        crc_err_q, crc_err_d;

    // One CAN CRC-15 step (polynomial 0x4599) for a single received bit.
    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic [14:0] s;
        s = {c[13:0], 1'b0};
        if (b ^ c[14]) s = s ^ 15'h4599;
        return s;
    endfunction

    // CRC accumulation from SOF through DATA, then bitwise compare during CRC.
    always_comb begin
        crc_d     = crc_q;
        crc_bad_d = crc_bad_q;
        if (bit_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        crc_d     = crc_step(15'd0, rx_bit);
                        crc_bad_d = 1'b0;
                    end
                end
                ST_ID_A, ST_SRR_RTR, ST_IDE, ST_ID_B, ST_RTR_B,
                ST_R1, ST_R0, ST_DLC, ST_DATA: begin
                    crc_d = crc_step(crc_q, rx_bit);
                end
                ST_CRC: begin
                    // Shift the computed CRC out MSB first alongside the received bits.
                    if (rx_bit != crc_q[14]) crc_bad_d = 1'b1;
                    crc_d = {crc_q[13:0], 1'b0};
                end
                default: ;
            endcase
        end
    end
`endif

    // Next-state logic: field walk, bit counting, field latching and pulses.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        ide_d        = ide_q;
        rtr_d        = rtr_q;
        dlc_d        = dlc_q;
        cap_clr_d    = 1'b0;
        frame_done_d = 1'b0;
        form_err_d   = 1'b0;
`ifdef CAN_CRC_CHECK_EN
        crc_err_d    = 1'b0;
`endif
        if (bit_valid) begin
            bit_cnt_d = bit_cnt_q + 7'd1;
            case (state_q)
                ST_INTEG: begin
                    // Any dominant bit restarts the bus-idle count.
                    if (!rx_bit) begin
                        bit_cnt_d = 7'd0;
                    end else if (bit_cnt_q == INTEG_LAST) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 7'd0;
                    end
                end
                ST_IDLE: begin
                    bit_cnt_d = 7'd0;
                    if (!rx_bit) begin
                        state_d   = ST_ID_A;
                        cap_clr_d = 1'b1;
                    end
                end
                ST_ID_A: begin
                    if (bit_cnt_q == 7'd10) begin
                        state_d   = ST_SRR_RTR;
                        bit_cnt_d = 7'd0;
                    end
                end
                ST_SRR_RTR: begin
                    // RTR for standard frames; overwritten by RTR_B in extended frames.
                    rtr_d     = rx_bit;
                    state_d   = ST_IDE;
                    bit_cnt_d = 7'd0;
                end
                ST_IDE: begin
                    ide_d     = rx_bit;
                    state_d   = rx_bit ? ST_ID_B : ST_R0;
                    bit_cnt_d = 7'd0;
                end
                ST_ID_B: begin
                    if (bit_cnt_q == 7'd17) begin
                        state_d   = ST_RTR_B;
                        bit_cnt_d = 7'd0;
                    end
                end
                ST_RTR_B: begin
                    rtr_d     = rx_bit;
                    state_d   = ST_R1;
                    bit_cnt_d = 7'd0;
                end
                ST_R1: begin
                    state_d   = ST_R0;
                    bit_cnt_d = 7'd0;
                end
                ST_R0: begin
                    state_d   = ST_DLC;
                    bit_cnt_d = 7'd0;
                end
                ST_DLC: begin
                    dlc_d = {dlc_q[2:0], rx_bit};
                    if (bit_cnt_q == 7'd3) begin
                        // Use the just-completed DLC to decide whether DATA exists.
                        state_d   = (data_len(dlc_d, rtr_q) == 7'd0) ? ST_CRC : ST_DATA;
                        bit_cnt_d = 7'd0;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_q == data_len(dlc_q, rtr_q) - 7'd1) begin
                        state_d   = ST_CRC;
                        bit_cnt_d = 7'd0;
                    end
                end
                ST_CRC: begin
                    if (bit_cnt_q == 7'd14) begin
                        state_d   = ST_CRC_DEL;
                        bit_cnt_d = 7'd0;
                    end
                end
                ST_CRC_DEL: begin
                    bit_cnt_d = 7'd0;
`ifdef CAN_CRC_CHECK_EN
                    if (crc_bad_q) begin
                        crc_err_d = 1'b1;
                        state_d   = ST_INTEG;
                    end else
`endif
                    if (!rx_bit) begin
                        form_err_d = 1'b1;
                        state_d    = ST_INTEG;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_d   = ST_ACK_DEL;
                    bit_cnt_d = 7'd0;
                end
                ST_ACK_DEL: begin
                    bit_cnt_d = 7'd0;
                    if (!rx_bit) begin
                        form_err_d = 1'b1;
                        state_d    = ST_INTEG;
                    end else begin
                        state_d = ST_EOF;
                    end
                end
                ST_EOF: begin
                    // Last EOF bit completes the frame whatever its value (overload).
                    if (bit_cnt_q == 7'd6) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                        bit_cnt_d    = 7'd0;
                    end else if (!rx_bit) begin
                        form_err_d = 1'b1;
                        state_d    = ST_INTEG;
                        bit_cnt_d  = 7'd0;
                    end
                end
                default: begin
                    state_d   = ST_INTEG;
                    bit_cnt_d = 7'd0;
                end
            endcase
        end
    end

    // State and registered outputs; reset aborts any frame into bus integration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INTEG;
            bit_cnt_q    <= 7'd0;
            ide_q        <= 1'b0;
            rtr_q        <= 1'b0;
            dlc_q        <= 4'd0;
            cap_clr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            form_err_q   <= 1'b0;
`ifdef CAN_CRC_CHECK_EN
            crc_q        <= 15'd0;
            crc_bad_q    <= 1'b0;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ide_q        <= ide_d;
            rtr_q        <= rtr_d;
            dlc_q        <= dlc_d;
            cap_clr_q    <= cap_clr_d;
            frame_done_q <= frame_done_d;
            form_err_q   <= form_err_d;
`ifdef CAN_CRC_CHECK_EN
            crc_q        <= crc_d;
            crc_bad_q    <= crc_bad_d;
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    assign field      = state_q;
    assign bit_cnt    = bit_cnt_q;
    assign ide        = ide_q;
    assign rtr        = rtr_q;
    assign dlc        = dlc_q;
    assign cap_clr    = cap_clr_q;
    assign frame_done = frame_done_q;
    assign form_err   = form_err_q;
`ifdef CAN_CRC_CHECK_EN
    assign crc_err    = crc_err_q;
`endif

    // Capture enable covers the header and data fields for the bit being presented now.
    assign cap_en = bit_valid && (state_q inside {ST_ID_A, ST_SRR_RTR, ST_IDE, ST_ID_B,
                                                  ST_RTR_B, ST_R1, ST_R0, ST_DLC, ST_DATA});

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Testbench for can_frame_sequencer: builds destuffed CAN frames bit by bit,
// predicts pulse events into a queue and compares them as the DUT emits them.
module tb_can_frame_sequencer;

  localparam logic [7:0] EV_CAP_CLR = 8'h01;
  localparam logic [7:0] EV_DONE    = 8'h02;
  localparam logic [7:0] EV_FORM    = 8'h03;
  localparam logic [7:0] EV_CRC     = 8'h04;

  logic       clk;
  logic       rst_n;
  logic       bit_valid;
  logic       rx_bit;
  logic       cap_clr;
  logic       cap_en;
  logic [3:0] field;
  logic [6:0] bit_cnt;
  logic       ide;
  logic       rtr;
  logic [3:0] dlc;
  logic       frame_done;
  logic       form_err;
`ifdef CAN_CRC_CHECK_EN
  logic       crc_err;
`else
  logic       crc_err;
  assign crc_err = 1'b0;
`endif

  logic [7:0] exp_q[$];
  logic       tx_q[$];
  int         n_checks;
  int         n_errors;
  int         cap_en_cnt;
  int         data_cnt;

  can_frame_sequencer #(.IDLE_BITS(11), .MAX_BYTES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .rx_bit     (rx_bit),
    .cap_clr    (cap_clr),
    .cap_en     (cap_en),
    .field      (field),
    .bit_cnt    (bit_cnt),
    .ide        (ide),
    .rtr        (rtr),
    .dlc        (dlc),
    .frame_done (frame_done),
`ifdef CAN_CRC_CHECK_EN
    .crc_err    (crc_err),
`endif
    .form_err   (form_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_event(input logic [7:0] code);
    logic [7:0] exp;
    exp = 8'hEE;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check_eq("event", {24'd0, code}, {24'd0, exp});
  endtask

  task automatic observe();
    if (cap_clr)    pop_event(EV_CAP_CLR);
    if (frame_done) pop_event(EV_DONE);
    if (form_err)   pop_event(EV_FORM);
    if (crc_err)    pop_event(EV_CRC);
  endtask

  // driver: present one bit for one cycle, optionally followed by an idle cycle
  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_valid = 1'b1;
    rx_bit    = b;
    #1;
    if (cap_en) cap_en_cnt++;
    if (field == 4'd10) data_cnt++;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    rx_bit    = 1'b1;
    observe();
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
      check_eq("pulse_len", {28'd0, cap_clr, frame_done, form_err, crc_err}, 32'd0);
    end
  endtask

  task automatic send_n(input int n, input logic b);
    for (int i = 0; i < n; i++) send_bit(b);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(tx_q[i]);
  endtask

  function automatic logic [14:0] crc_next(input logic [14:0] c, input logic b);
    logic [14:0] s;
    s = {c[13:0], 1'b0};
    if (b ^ c[14]) s = s ^ 15'h4599;
    return s;
  endfunction

  // Build a destuffed frame (SOF..EOF) into tx_q with a correct CRC.
  task automatic build_frame(input logic ext, input logic [28:0] id, input logic r,
                             input logic [3:0] d, input logic [63:0] data);
    logic [14:0] crc;
    int          nb;
    tx_q.delete();
    tx_q.push_back(1'b0);
    if (ext) begin
      for (int i = 28; i >= 18; i--) tx_q.push_back(id[i]);
      tx_q.push_back(1'b1);
      tx_q.push_back(1'b1);
      for (int i = 17; i >= 0; i--) tx_q.push_back(id[i]);
      tx_q.push_back(r);
      tx_q.push_back(1'b0);
      tx_q.push_back(1'b0);
    end else begin
      for (int i = 10; i >= 0; i--) tx_q.push_back(id[i]);
      tx_q.push_back(r);
      tx_q.push_back(1'b0);
      tx_q.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) tx_q.push_back(d[i]);
    nb = (d > 4'd8) ? 8 : int'(d);
    if (r) nb = 0;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < 8; k++) tx_q.push_back(data[63 - 8 * i - k]);
    crc = 15'd0;
    foreach (tx_q[i]) crc = crc_next(crc, tx_q[i]);
    for (int i = 14; i >= 0; i--) tx_q.push_back(crc[i]);
    tx_q.push_back(1'b1);
    tx_q.push_back(1'b0);
    tx_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) tx_q.push_back(1'b1);
  endtask

  task automatic clear_counts();
    cap_en_cnt = 0;
    data_cnt   = 0;
  endtask

  initial begin
    int sz;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    rx_bit    = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // reset values
    check_eq("rst_field", {28'd0, field}, 32'd1);
    check_eq("rst_bit_cnt", {25'd0, bit_cnt}, 32'd0);
    check_eq("rst_ide_rtr", {30'd0, ide, rtr}, 32'd0);
    check_eq("rst_dlc", {28'd0, dlc}, 32'd0);
    check_eq("rst_pulses", {28'd0, cap_clr, frame_done, form_err, crc_err}, 32'd0);
    check_eq("rst_cap_en", {31'd0, cap_en}, 32'd0);

    // bus integration: a dominant bit restarts the idle count
    send_n(10, 1'b1);
    send_bit(1'b0);
    check_eq("integ_restart_field", {28'd0, field}, 32'd1);
    check_eq("integ_restart_cnt", {25'd0, bit_cnt}, 32'd0);
    send_n(10, 1'b1);
    check_eq("integ_10_field", {28'd0, field}, 32'd1);
    check_eq("integ_10_cnt", {25'd0, bit_cnt}, 32'd10);
    send_bit(1'b1);
    check_eq("integ_idle_field", {28'd0, field}, 32'd0);
    send_n(3, 1'b1);
    check_eq("idle_ignores_recessive", {28'd0, field}, 32'd0);

    // standard data frame ID 0x123, DLC 2
    build_frame(1'b0, 29'h123, 1'b0, 4'd2, 64'hA53C_0000_0000_0000);
    exp_q.push_back(EV_CAP_CLR);
    exp_q.push_back(EV_DONE);
    clear_counts();
    run_range(0, tx_q.size() - 1);
    check_eq("std_cap_en_bits", cap_en_cnt, 32'd34);
    check_eq("std_data_bits", data_cnt, 32'd16);
    check_eq("std_ide", {31'd0, ide}, 32'd0);
    check_eq("std_rtr", {31'd0, rtr}, 32'd0);
    check_eq("std_dlc", {28'd0, dlc}, 32'd2);
    check_eq("std_field_idle", {28'd0, field}, 32'd0);
    check_eq("std_bit_cnt", {25'd0, bit_cnt}, 32'd0);
    check_eq("std_pending", exp_q.size(), 32'd0);

    // extended remote frame sent back to back: DATA is skipped
    build_frame(1'b1, 29'h1ABCDE01, 1'b1, 4'd4, 64'h0);
    exp_q.push_back(EV_CAP_CLR);
    exp_q.push_back(EV_DONE);
    clear_counts();
    run_range(0, tx_q.size() - 1);
    check_eq("ext_ide", {31'd0, ide}, 32'd1);
    check_eq("ext_rtr", {31'd0, rtr}, 32'd1);
    check_eq("ext_dlc", {28'd0, dlc}, 32'd4);
    check_eq("ext_data_bits", data_cnt, 32'd0);
    check_eq("ext_cap_en_bits", cap_en_cnt, 32'd38);
    check_eq("ext_field_idle", {28'd0, field}, 32'd0);
    check_eq("ext_pending", exp_q.size(), 32'd0);

    // DLC 15 clamps to 8 data bytes
    build_frame(1'b0, 29'h7F0, 1'b0, 4'd15, {$urandom(), $urandom()});
    exp_q.push_back(EV_CAP_CLR);
    exp_q.push_back(EV_DONE);
    clear_counts();
    run_range(0, tx_q.size() - 1);
    check_eq("dlc15_data_bits", data_cnt, 32'd64);
    check_eq("dlc15_dlc", {28'd0, dlc}, 32'd15);
    check_eq("dlc15_pending", exp_q.size(), 32'd0);

    // dominant CRC delimiter: form error, no frame_done
    build_frame(1'b0, 29'h055, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
    sz = tx_q.size();
    tx_q[sz - 10] = 1'b0;
    exp_q.push_back(EV_CAP_CLR);
    exp_q.push_back(EV_FORM);
    run_range(0, sz - 10);
    check_eq("crcdel_field", {28'd0, field}, 32'd1);
    check_eq("crcdel_pending", exp_q.size(), 32'd0);
    send_n(11, 1'b1);
    check_eq("crcdel_reinteg", {28'd0, field}, 32'd0);

    // dominant EOF bit 2: form error
    build_frame(1'b0, 29'h3AA, 1'b0, 4'd0, 64'h0);
    sz = tx_q.size();
    tx_q[sz - 5] = 1'b0;
    exp_q.push_back(EV_CAP_CLR);
    exp_q.push_back(EV_FORM);
    run_range(0, sz - 5);
    check_eq("eof2_field", {28'd0, field}, 32'd1);
    check_eq("eof2_pending", exp_q.size(), 32'd0);
    send_n(11, 1'b1);

    // dominant last EOF bit: accepted, frame completes
    build_frame(1'b0, 29'h1C3, 1'b0, 4'd3, 64'h1122_3300_0000_0000);
    sz = tx_q.size();
    tx_q[sz - 1] = 1'b0;
    exp_q.push_back(EV_CAP_CLR);
    exp_q.push_back(EV_DONE);
    run_range(0, sz - 1);
    check_eq("eof6_field", {28'd0, field}, 32'd0);
    check_eq("eof6_pending", exp_q.size(), 32'd0);

    // reset asserted while DATA bit 20 is presented
    build_frame(1'b0, 29'h2F1, 1'b0, 4'd8, {$urandom(), $urandom()});
    exp_q.push_back(EV_CAP_CLR);
    run_range(0, 38);
    check_eq("mid_field_data", {28'd0, field}, 32'd10);
    check_eq("mid_bit_cnt", {25'd0, bit_cnt}, 32'd20);
    check_eq("mid_dlc", {28'd0, dlc}, 32'd8);
    @(negedge clk);
    bit_valid = 1'b1;
    rx_bit    = tx_q[39];
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_field", {28'd0, field}, 32'd1);
    check_eq("arst_bit_cnt", {25'd0, bit_cnt}, 32'd0);
    check_eq("arst_dlc", {28'd0, dlc}, 32'd0);
    check_eq("arst_ide_rtr", {30'd0, ide, rtr}, 32'd0);
    check_eq("arst_pulses", {28'd0, cap_clr, frame_done, form_err, crc_err}, 32'd0);
    @(posedge clk);
    #1;
    observe();
    @(negedge clk);
    bit_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check_eq("arst_hold_field", {28'd0, field}, 32'd1);
    send_n(11, 1'b1);
    check_eq("arst_reinteg", {28'd0, field}, 32'd0);

`ifdef CAN_CRC_CHECK_EN
    // corrupted CRC bit: crc_err at the delimiter, no frame_done
    build_frame(1'b0, 29'h123, 1'b0, 4'd2, 64'hA53C_0000_0000_0000);
    sz = tx_q.size();
    tx_q[sz - 12] = ~tx_q[sz - 12];
    exp_q.push_back(EV_CAP_CLR);
    exp_q.push_back(EV_CRC);
    run_range(0, sz - 10);
    check_eq("crcerr_field", {28'd0, field}, 32'd1);
    check_eq("crcerr_pending", exp_q.size(), 32'd0);
    send_n(11, 1'b1);
`endif

    repeat (3) @(posedge clk);
    check_eq("final_pending", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
